spi_device: RTL and testbench



---
 rtl/spi_device_if.sv | 23 ++
 rtl/spi_device.sv | 142 ++++++++++++++
 tb/tb_spi_device.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_device_if.sv
// Pin and byte-stream bundle for spi_device: SPI pins from the host plus
// the rx/tx byte handshake with the control block.
interface spi_device_if;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [7:0] tx_data;
  logic       tx_strobe;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, tx_data, tx_strobe,
    output spi_miso, spi_cs, rx_data, rx_strobe
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, tx_data, tx_strobe,
    input  spi_miso, spi_cs, rx_data, rx_strobe
  );
endinterface

// File: rtl/spi_device.sv
// SPI mode 0 target, MSB first, 8-bit frames, pins oversampled on clk.
// Define SPI_MISO_HIZ_EN to float MISO while deselected (shared MISO bus).
module spi_device #(
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        reset,
  spi_device_if.slave bus
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} stateT;

  localparam int CntW = $clog2(SYNC_STAGES + 1);

  stateT r_state, w_stateNext;

  logic [SYNC_STAGES-1:0] r_sckSync, r_csSync, r_mosiSync;
  logic                   r_sckPrev;
  logic [CntW-1:0]        r_syncCnt;
  logic [7:0]             r_rxShift, r_rxData, r_txShift, r_txHold;
  logic [2:0]             r_bitCount;
  logic                   r_txValid, r_reload, r_rxStrobe;

  logic       w_sckCur, w_sckRise, w_sckFall, w_csCur, w_mosi, w_syncReady, w_load;
  logic [7:0] w_txNext, w_rxByte;

  assign w_sckCur    = r_sckSync[SYNC_STAGES-1];
  assign w_csCur     = r_csSync[SYNC_STAGES-1];
  assign w_mosi      = r_mosiSync[SYNC_STAGES-1];
  assign w_sckRise   = w_sckCur & ~r_sckPrev;
  assign w_sckFall   = ~w_sckCur & r_sckPrev;
  assign w_syncReady = (r_syncCnt == CntW'(SYNC_STAGES));
  assign w_txNext    = r_txValid ? r_txHold : 8'h00;
  assign w_rxByte    = {r_rxShift[6:0], w_mosi};
  assign w_load      = ((r_state == IDLE) && !w_csCur) ||
                       ((r_state == ACTIVE) && w_sckFall && r_reload);

  // The fill counter keeps WAIT_IDLE from trusting the reset value of the CS
  // chain; only a CS high that has actually travelled through it counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sckSync  <= '0;
      r_csSync   <= '1;
      r_mosiSync <= '0;
      r_sckPrev  <= 1'b0;
      r_syncCnt  <= '0;
    end else begin
      r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], bus.spi_sck};
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], bus.spi_cs_n};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sckPrev  <= w_sckCur;
      if (!w_syncReady) r_syncCnt <= r_syncCnt + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      WAIT_IDLE: if (w_syncReady && w_csCur) w_stateNext = IDLE;
      IDLE:      if (!w_csCur) w_stateNext = ACTIVE;
      ACTIVE:    if (w_csCur) w_stateNext = IDLE;
      default:   w_stateNext = WAIT_IDLE;
    endcase
  end

  // A strobe landing in the same cycle as a consumption stays valid; the
  // consumer has already taken the old holding value through w_txNext.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_txHold  <= 8'h00;
      r_txValid <= 1'b0;
    end else if (bus.tx_strobe) begin
      r_txHold  <= bus.tx_data;
      r_txValid <= 1'b1;
    end else if (w_load) begin
      r_txValid <= 1'b0;
    end
  end

  // Rising edges are handled before the CS-driven exit, so a byte whose last
  // SCK rise coincides with CS rising still completes and strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxShift  <= 8'h00;
      r_rxData   <= 8'h00;
      r_rxStrobe <= 1'b0;
      r_txShift  <= 8'h00;
      r_bitCount <= 3'd0;
      r_reload   <= 1'b0;
    end else begin
      r_rxStrobe <= 1'b0;
      case (r_state)
        ACTIVE: begin
          if (w_sckRise) begin
            r_rxShift <= w_rxByte;
            if (r_bitCount == 3'd7) begin
              r_rxData   <= w_rxByte;
              r_rxStrobe <= 1'b1;
              r_bitCount <= 3'd0;
              r_reload   <= 1'b1;
            end else begin
              r_bitCount <= r_bitCount + 3'd1;
            end
          end
          if (w_sckFall) begin
            if (r_reload) begin
              r_txShift <= w_txNext;
              r_reload  <= 1'b0;
            end else begin
              r_txShift <= {r_txShift[6:0], 1'b0};
            end
          end
        end
        IDLE: begin
          r_bitCount <= 3'd0;
          r_reload   <= 1'b0;
          if (!w_csCur) r_txShift <= w_txNext;
        end
        default: begin
          r_bitCount <= 3'd0;
          r_reload   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.spi_cs    = w_csCur;
  assign bus.rx_data   = r_rxData;
  assign bus.rx_strobe = r_rxStrobe;

`ifdef SPI_MISO_HIZ_EN
  assign bus.spi_miso = (w_csCur || (r_state == WAIT_IDLE)) ? 1'bz : r_txShift[7];
`else
  assign bus.spi_miso = (w_csCur || (r_state == WAIT_IDLE)) ? 1'b0 : r_txShift[7];
`endif

endmodule

// File: tb/tb_spi_device.sv
// Scoreboard bench for spi_device: a host model clocks bytes in mode 0 and
// expected rx bytes are queued as sent, then matched against rx_strobe.
module tb_spi_device;

  localparam int SyncStages   = 2;
  localparam int LatencyLimit = SyncStages + 2;
`ifdef SPI_MISO_HIZ_EN
  localparam logic IdleMiso = 1'bz;
`else
  localparam logic IdleMiso = 1'b0;
`endif

  logic clock;
  logic reset;

  spi_device_if bus();

  spi_device #(.SYNC_STAGES(SyncStages)) dut (
    .clk   (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checkCount    = 0;
  int failCount     = 0;
  int cycleCount    = 0;
  int lastRiseCycle = 0;
  int strobeCount   = 0;
  logic [7:0] rxQ[$];
  logic [7:0] respQ[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever @(posedge clock) cycleCount++;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest queued byte in time.
  initial begin
    logic [7:0] expByte;
    logic       onTime;
    forever begin
      @(negedge clock);
      if (bus.rx_strobe === 1'b1) begin
        strobeCount++;
        checkOutput("rxQueued", {7'd0, rxQ.size() != 0}, 8'd1);
        if (rxQ.size() != 0) begin
          expByte = rxQ.pop_front();
          checkOutput("rxData", bus.rx_data, expByte);
          onTime = (cycleCount - lastRiseCycle) <= LatencyLimit;
          checkOutput("rxLatency", {7'd0, onTime}, 8'd1);
        end
      end
    end
  end

  // Plays the control block: answers a received byte with a queued response.
  initial begin
    forever begin
      @(negedge clock);
      if (bus.rx_strobe === 1'b1 && respQ.size() != 0) begin
        bus.tx_data   = respQ.pop_front();
        bus.tx_strobe = 1'b1;
        @(negedge clock);
        bus.tx_strobe = 1'b0;
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clock);
    $display("[TB] FAIL watchdog cycles=%0d limit=50000", cycleCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sendBit(input logic mosiBit, output logic misoBit);
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = mosiBit;
    repeat (4) @(negedge clock);
    misoBit       = bus.spi_miso;
    bus.spi_sck   = 1'b1;
    lastRiseCycle = cycleCount;
    repeat (4) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [7:0] mosiByte, output logic [7:0] misoByte);
    logic b;
    rxQ.push_back(mosiByte);
    for (int i = 7; i >= 0; i--) begin
      sendBit(mosiByte[i], b);
      misoByte[i] = b;
    end
  endtask

  task automatic csLow();
    bus.spi_cs_n = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic csHigh();
    bus.spi_sck = 1'b0;
    repeat (4) @(negedge clock);
    bus.spi_cs_n = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic loadTx(input logic [7:0] value);
    bus.tx_data   = value;
    bus.tx_strobe = 1'b1;
    @(negedge clock);
    bus.tx_strobe = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] misoByte;
    logic       b;
    int         s0;

    bus.spi_sck   = 1'b0;
    bus.spi_cs_n  = 1'b1;
    bus.spi_mosi  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.tx_strobe = 1'b0;
    reset         = 1'b1;
    repeat (4) @(negedge clock);

    checkOutput("resetCs", {7'd0, bus.spi_cs}, 8'd1);
    checkOutput("resetRxData", bus.rx_data, 8'h00);
    checkOutput("resetRxStrobe", {7'd0, bus.rx_strobe}, 8'd0);
    checkOutput("resetMiso", {7'd0, bus.spi_miso}, {7'd0, IdleMiso});
    reset = 1'b0;
    repeat (8) @(negedge clock);

    // Single byte, nothing queued for transmit.
    s0 = strobeCount;
    csLow();
    applyStimulus(8'h05, misoByte);
    csHigh();
    checkOutput("t1Miso", misoByte, 8'h00);
    checkOutput("t1Strobes", 8'(strobeCount - s0), 8'd1);
    checkOutput("t1IdleMiso", {7'd0, bus.spi_miso}, {7'd0, IdleMiso});

    // Response loaded while idle, consumed by the first byte only.
    s0 = strobeCount;
    loadTx(8'hA5);
    csLow();
    applyStimulus(8'h00, misoByte);
    checkOutput("t2MisoA5", misoByte, 8'hA5);
    applyStimulus(8'h00, misoByte);
    checkOutput("t2MisoEmpty", misoByte, 8'h00);
    csHigh();
    checkOutput("t2Strobes", 8'(strobeCount - s0), 8'd2);

    // Back-to-back bytes with the response issued after the first strobe.
    s0 = strobeCount;
    respQ.push_back(8'h3F);
    csLow();
    applyStimulus(8'h05, misoByte);
    checkOutput("t3Byte1", misoByte, 8'h00);
    applyStimulus(8'h00, misoByte);
    checkOutput("t3Byte2", misoByte, 8'h3F);
    applyStimulus(8'h00, misoByte);
    checkOutput("t3Byte3", misoByte, 8'h00);
    csHigh();
    checkOutput("t3Strobes", 8'(strobeCount - s0), 8'd3);
    checkOutput("t3RespUsed", 8'(respQ.size()), 8'd0);

    // Partial byte aborted by CS, then a full byte.
    s0 = strobeCount;
    csLow();
    for (int i = 0; i < 5; i++) sendBit(1'b1, b);
    csHigh();
    checkOutput("t4NoPartial", 8'(strobeCount - s0), 8'd0);
    csLow();
    applyStimulus(8'h81, misoByte);
    csHigh();
    checkOutput("t4Strobes", 8'(strobeCount - s0), 8'd1);
    checkOutput("t4RxData", bus.rx_data, 8'h81);

    // Reset in mid-frame: remainder of the frame must be ignored.
    s0 = strobeCount;
    csLow();
    sendBit(1'b0, b);
    sendBit(1'b1, b);
    sendBit(1'b0, b);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) sendBit(1'b1, b);
    csHigh();
    checkOutput("t5NoStrobe", 8'(strobeCount - s0), 8'd0);
    checkOutput("t5RxCleared", bus.rx_data, 8'h00);
    csLow();
    applyStimulus(8'h42, misoByte);
    csHigh();
    checkOutput("t5Strobes", 8'(strobeCount - s0), 8'd1);
    checkOutput("t5RxData", bus.rx_data, 8'h42);

    // First MISO bit is presented before any SCK rise.
    loadTx(8'h80);
    checkOutput("t6IdleMiso", {7'd0, bus.spi_miso}, {7'd0, IdleMiso});
    csLow();
    checkOutput("t6FirstBit", {7'd0, bus.spi_miso}, 8'd1);
    applyStimulus(8'h00, misoByte);
    checkOutput("t6Miso", misoByte, 8'h80);
    csHigh();
    checkOutput("t6EndMiso", {7'd0, bus.spi_miso}, {7'd0, IdleMiso});

    repeat (20) @(negedge clock);
    checkOutput("rxPending", 8'(rxQ.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
